// File: rtl/data_mem_responder.sv
// Purpose: data-memory bus responder with a word-organised RAM, byte/half/word writes and a shared tri-state data bus.
// Latency: ACKD_n is low for one cycle, in the (WAIT_CYCLES+1)-th cycle after the edge that accepts the request.
// Backpressure: a new request is sampled only in IDLE, so MREQ held high is accepted every WAIT_CYCLES+2 cycles.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    output logic        ACKD_n
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] lat_addr;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic [31:0] lat_wdat;
    logic [31:0] rd_dat;
    logic        ddt_oe;

    logic [31:0] mem [DEPTH_WORDS];

    logic [3:0]  wr_be;
    logic [31:0] wr_dat;

    // Address lies inside the window [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
    function automatic logic addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    // Word index of a byte address relative to the window base.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    // The responder only drives the bus while acknowledging a read.
    assign DDT = ddt_oe ? rd_dat : 32'hzzzz_zzzz;

    // Request FSM: latch request, count wait states, pulse a registered acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_wdat  <= '0;
            rd_dat    <= '0;
            ACKD_n    <= 1'b1;
            ddt_oe    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MREQ) begin
                        lat_addr  <= DAD;
                        lat_write <= WRITE;
                        lat_size  <= SIZE;
                        lat_wdat  <= DDT;
                        if (WAIT_CYCLES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            // No wait states: the read word comes straight from the live address.
                            state  <= ST_ACK;
                            ACKD_n <= 1'b0;
                            ddt_oe <= !WRITE;
                            rd_dat <= addr_hit(DAD) ? mem[word_idx(DAD)] : 32'h0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state  <= ST_ACK;
                        ACKD_n <= 1'b0;
                        ddt_oe <= !lat_write;
                        rd_dat <= addr_hit(lat_addr) ? mem[word_idx(lat_addr)] : 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ACKD_n <= 1'b1;
                    ddt_oe <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane enables and lane-replicated write data from the latched request.
    always_comb begin
        wr_be  = 4'hF;
        wr_dat = lat_wdat;
        case (lat_size)
            2'b01: begin
                wr_be  = lat_addr[1] ? 4'b1100 : 4'b0011;
                wr_dat = {2{lat_wdat[15:0]}};
            end
            2'b10: begin
                wr_be  = 4'b0001 << lat_addr[1:0];
                wr_dat = {4{lat_wdat[7:0]}};
            end
            default: begin
                wr_be  = 4'hF;
                wr_dat = lat_wdat;
            end
        endcase
    end

    // Commit an in-range write on the edge that leaves ACK; the array is never reset.
    always_ff @(posedge clk) begin
        if (state == ST_ACK && lat_write && addr_hit(lat_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx(lat_addr)][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder (slave) end of the CPU data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It models word-organised data RAM with configurable wait states, byte/halfword/word writes and a tri-state shared data bus. It sits outside top and is instantiated in the system/testbench level alongside the instruction memory.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 of the array
DEPTH_WORDS, 16384, number of 32-bit words; power of two, >= 2
WAIT_CYCLES, 0, wait cycles between request acceptance and acknowledge; 0..15

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
DAD  input  32  byte address from requester
DDT  inout  32  data bus; driven by responder only during a read acknowledge, otherwise hi-Z
MREQ  input  1  1 = access requested
WRITE  input  1  1 = write, 0 = read; valid with MREQ
SIZE  input  2  2'b00 word, 2'b01 halfword, 2'b10 byte, 2'b11 treated as word
ACKD_n  output  1  0 = access completes this cycle, 1 = not ready

Behaviour:
- Reset (async, rst_n=0): state IDLE, wait counter 0, ACKD_n=1, DDT hi-Z, latched request cleared. Array contents unaffected. Reset during WAIT/ACK aborts the access; a pending write is not committed.
- FSM IDLE -> WAIT -> ACK -> IDLE.
- IDLE: at a rising edge with MREQ=1, latch DAD, WRITE, SIZE and DDT (write data); go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go directly to ACK. MREQ=0: stay.
- WAIT: counter decrements each edge; at counter 0 go to ACK. MREQ/DAD/DDT changes ignored (latched copy used).
- ACK: ACKD_n=0 for exactly one cycle; next state IDLE unconditionally. MREQ ignored in ACK; a request is re-sampled only from IDLE, so minimum spacing between two accepted requests is WAIT_CYCLES+2 cycles. ACKD_n is a registered output (state==ACK), no combinational path from inputs.
- Latency: ACKD_n low in the (WAIT_CYCLES+1)-th cycle after the accepting edge.
- Address decode: off = latched DAD - BASE_ADDR; index = off[log2(DEPTH_WORDS)+1:2]; in range iff DAD >= BASE_ADDR and off < 4*DEPTH_WORDS.
- Read: array word registered on entry to ACK; DDT = full aligned 32-bit word during ACK cycle only (requester performs lane extraction and extension). Out-of-range read returns 32'h0000_0000.
- Write: commit at the edge leaving ACK. Source data is the low lanes of latched DDT: word DDT[31:0] (DAD[1:0] ignored); halfword DDT[15:0] to lanes selected by DAD[1] (0 -> [15:0], 1 -> [31:16]), DAD[0] ignored; byte DDT[7:0] to lane DAD[1:0]. Unselected byte lanes unchanged. Little-endian. Out-of-range write dropped, still acknowledged. DDT never driven during a write.
- Bus contention: responder output enable asserted only when state==ACK and latched WRITE=0.

Test Plan:
- Reset then idle: rst_n=0 mid-WAIT (WAIT_CYCLES=3) after MREQ=1 WRITE=1 DAD=BASE+0x10 -> ACKD_n=1, DDT=Z, word 4 unchanged after reset release.
- Word write/read, WAIT_CYCLES=0: write 32'hDEAD_BEEF to BASE+0x8 -> ACKD_n low 1 cycle after accept; read BASE+0x8 -> DDT=32'hDEAD_BEEF during ACK cycle only, Z otherwise.
- Byte/half merge: word BASE+0x0 = 32'h1122_3344; byte write DDT[7:0]=8'hAA at DAD=BASE+0x2; half write DDT[15:0]=16'hBBCC at DAD=BASE+0x0 -> read returns 32'h11AA_BBCC.
- Wait states: WAIT_CYCLES=3, read accepted at edge N -> ACKD_n=0 only in cycle N+4; DAD changed during WAIT has no effect on returned data.
- Held MREQ: MREQ held 1 across ACK with WAIT_CYCLES=0 -> acknowledges every 2nd cycle (accept, ACK, accept, ...), never two consecutive ACK cycles.
- Out of range: write 32'h1234_5678 to BASE+4*DEPTH_WORDS -> ACKD_n pulses, array unchanged; read same address -> DDT=32'h0.
